// File: rtl/fir_mac_scheduler_if.sv
// Frame, coefficient-ROM and result bundle for fir_mac_scheduler.
// The slave side is the scheduler; the master side is its environment.
interface fir_mac_scheduler_if #(
    parameter int TAPS = 32,
    parameter int DW   = 24,
    parameter int CW   = 18
);
    localparam int KW = $clog2(TAPS);

    logic          in_valid;
    logic [DW-1:0] in_l;
    logic [DW-1:0] in_r;
    logic [KW-1:0] coef_addr;
    logic [CW-1:0] coef_data;
    logic          out_valid;
    logic [DW-1:0] out_l;
    logic [DW-1:0] out_r;
    logic          busy;
    logic          overrun;

    modport master (
        output in_valid, in_l, in_r, coef_data,
        input  coef_addr, out_valid, out_l, out_r, busy, overrun
    );

    modport slave (
        input  in_valid, in_l, in_r, coef_data,
        output coef_addr, out_valid, out_l, out_r, busy, overrun
    );
endinterface

// File: rtl/fir_mac_scheduler.sv
// Shares one MAC between the left and right FIR channels, one frame at a time.
// Delay lines are circular; coefficients come from a 1-cycle synchronous ROM.
module fir_mac_scheduler #(
    parameter int TAPS     = 32,
    parameter int DW       = 24,
    parameter int CW       = 18,
    parameter int CFRAC    = 17,
    parameter bit BYPASS_R = 1'b1
) (
    input  logic               clk100,
    input  logic               rst_n,
    fir_mac_scheduler_if.slave bus
);
    localparam int KW = $clog2(TAPS);
    localparam int PW = DW + CW;
    localparam int AW = PW + KW;
    localparam logic [KW-1:0] K_LAST = KW'(TAPS - 1);
    localparam logic signed [AW:0] RND =
        {{AW{1'b0}}, 1'b1} << (CFRAC - 1);
    localparam logic signed [AW:0] SMAX =
        {{(AW - DW + 2){1'b0}}, {(DW - 1){1'b1}}};
    localparam logic signed [AW:0] SMIN =
        {{(AW - DW + 2){1'b1}}, {(DW - 1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE, LOAD, MAC_L, DRAIN_L, MAC_R, DRAIN_R, OUTPUT
    } state_t;

    state_t               state_q, state_d;
    logic [KW-1:0]        k_q, k_d;
    logic [1:0]           dcnt_q, dcnt_d;
    logic [KW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [DW-1:0]        lat_l_q, lat_l_d;
    logic [DW-1:0]        lat_r_q, lat_r_d;
    logic [DW-1:0]        dl_l_q [TAPS];
    logic [DW-1:0]        dl_l_d [TAPS];
    logic [DW-1:0]        dl_r_q [TAPS];
    logic [DW-1:0]        dl_r_d [TAPS];
    logic signed [DW-1:0] samp_q, samp_d;
    logic                 v1_q, v1_d;
    logic                 v2_q, v2_d;
    logic signed [PW-1:0] prod_q, prod_d;
    logic [AW-1:0]        acc_q, acc_d;
    logic [DW-1:0]        res_l_q, res_l_d;
    logic [DW-1:0]        res_r_q, res_r_d;
    logic [DW-1:0]        out_l_q, out_l_d;
    logic [DW-1:0]        out_r_q, out_r_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;
    logic                 ovr_q, ovr_d;

    logic                 in_mac;
    logic [KW-1:0]        rd_idx;
    logic signed [AW:0]   rnd;
    logic signed [AW:0]   shr;
    logic [DW-1:0]        result;

    assign in_mac = (state_q == MAC_L) || (state_q == MAC_R);
    assign rd_idx = wr_ptr_q - k_q;

    assign bus.coef_addr = in_mac ? k_q : '0;
    assign bus.out_valid = out_valid_q;
    assign bus.out_l     = out_l_q;
    assign bus.out_r     = out_r_q;
    assign bus.busy      = busy_q;
    assign bus.overrun   = ovr_q;

    // Round half up, then clamp the accumulator into the sample range
    always_comb begin
        rnd = $signed({acc_q[AW-1], acc_q}) + RND;
        shr = rnd >>> CFRAC;
        if (shr > SMAX) begin
            result = SMAX[DW-1:0];
        end else if (shr < SMIN) begin
            result = SMIN[DW-1:0];
        end else begin
            result = shr[DW-1:0];
        end
    end

    // Frame sequencing: load, per-channel MAC sweep, drain, publish
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        dcnt_d      = dcnt_q;
        wr_ptr_d    = wr_ptr_q;
        lat_l_d     = lat_l_q;
        lat_r_d     = lat_r_q;
        dl_l_d      = dl_l_q;
        dl_r_d      = dl_r_q;
        res_l_d     = res_l_q;
        res_r_d     = res_r_q;
        out_l_d     = out_l_q;
        out_r_d     = out_r_q;
        out_valid_d = 1'b0;
        ovr_d       = bus.in_valid && (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    lat_l_d = bus.in_l;
                    lat_r_d = bus.in_r;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                dl_l_d[wr_ptr_q] = lat_l_q;
                dl_r_d[wr_ptr_q] = lat_r_q;
                k_d              = '0;
                state_d          = MAC_L;
            end
            MAC_L, MAC_R: begin
                k_d = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    dcnt_d  = '0;
                    state_d = (state_q == MAC_L) ? DRAIN_L : DRAIN_R;
                end
            end
            DRAIN_L: begin
                dcnt_d = dcnt_q + 2'd1;
                if (dcnt_q == 2'd2) begin
                    res_l_d = result;
                    state_d = BYPASS_R ? OUTPUT : MAC_R;
                end
            end
            DRAIN_R: begin
                dcnt_d = dcnt_q + 2'd1;
                if (dcnt_q == 2'd2) begin
                    res_r_d = result;
                    state_d = OUTPUT;
                end
            end
            OUTPUT: begin
                out_l_d     = res_l_q;
                out_r_d     = BYPASS_R ? lat_r_q : res_r_q;
                out_valid_d = 1'b1;
                wr_ptr_d    = wr_ptr_q + 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // MAC pipeline: sample aligned to ROM latency, product, accumulate
    always_comb begin
        samp_d = (state_q == MAC_R) ? dl_r_q[rd_idx] : dl_l_q[rd_idx];
        v1_d   = in_mac;
        v2_d   = v1_q;
        prod_d = $signed({{CW{samp_q[DW-1]}}, samp_q}) *
                 $signed({{DW{bus.coef_data[CW-1]}}, bus.coef_data});
        acc_d  = acc_q;
        if (state_q == LOAD ||
            (state_q == DRAIN_L && dcnt_q == 2'd2)) begin
            acc_d = '0;
        end else if (v2_q) begin
            acc_d = acc_q + {{KW{prod_q[PW-1]}}, prod_q};
        end
    end

    // State and datapath registers; reset aborts any frame in flight
    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            dcnt_q      <= '0;
            wr_ptr_q    <= '0;
            lat_l_q     <= '0;
            lat_r_q     <= '0;
            dl_l_q      <= '{default: '0};
            dl_r_q      <= '{default: '0};
            samp_q      <= '0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            prod_q      <= '0;
            acc_q       <= '0;
            res_l_q     <= '0;
            res_r_q     <= '0;
            out_l_q     <= '0;
            out_r_q     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            dcnt_q      <= dcnt_d;
            wr_ptr_q    <= wr_ptr_d;
            lat_l_q     <= lat_l_d;
            lat_r_q     <= lat_r_d;
            dl_l_q      <= dl_l_d;
            dl_r_q      <= dl_r_d;
            samp_q      <= samp_d;
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            prod_q      <= prod_d;
            acc_q       <= acc_d;
            res_l_q     <= res_l_d;
            res_r_q     <= res_r_d;
            out_l_q     <= out_l_d;
            out_r_q     <= out_r_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            ovr_q       <= ovr_d;
        end
    end
endmodule
